// File: rtl/tsc_pkg.sv
// Shared constants for the TSC rare-event generator: block width, sequence
// state encoding and the default plaintext patterns/mask.
package tsc_pkg;

    localparam int BLOCK_W = 128;

    localparam logic [2:0] S0    = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S2    = 3'd2;
    localparam logic [2:0] S3    = 3'd3;
    localparam logic [2:0] ARMED = 3'd4;

    localparam logic [BLOCK_W-1:0] P0_DEF    = 128'h1;
    localparam logic [BLOCK_W-1:0] P1_DEF    = 128'h2;
    localparam logic [BLOCK_W-1:0] P2_DEF    = 128'h3;
    localparam logic [BLOCK_W-1:0] P3_DEF    = 128'h4;
    localparam logic [BLOCK_W-1:0] PMASK_DEF = {BLOCK_W{1'b1}};

endpackage

// File: rtl/tsc_pattern_cmp.sv
// Masked equality compare of one plaintext block against a fixed pattern.
module tsc_pattern_cmp
    import tsc_pkg::*;
#(
    parameter logic [BLOCK_W-1:0] PATTERN = P0_DEF,
    parameter logic [BLOCK_W-1:0] MASK    = PMASK_DEF
) (
    input  logic [BLOCK_W-1:0] state,
    output logic               match
);

    assign match = ((state & MASK) == (PATTERN & MASK));

endmodule

// File: rtl/tsc_rare_event_gen.sv
// Rare-condition qualifiers r1 (sticky P0..P3 sequence match) and r2 (byte
// occurrence threshold). Optional ARMED idle timeout: TSC_ARM_TIMEOUT_EN.
module tsc_rare_event_gen
    import tsc_pkg::*;
#(
    parameter logic [BLOCK_W-1:0] P0        = P0_DEF,
    parameter logic [BLOCK_W-1:0] P1        = P1_DEF,
    parameter logic [BLOCK_W-1:0] P2        = P2_DEF,
    parameter logic [BLOCK_W-1:0] P3        = P3_DEF,
    parameter logic [BLOCK_W-1:0] PMASK     = PMASK_DEF,
    parameter logic [7:0]         R2_BYTE   = 8'hA5,
    parameter logic [7:0]         R2_THRESH = 8'd3,
    parameter logic [15:0]        TIMEOUT   = 16'd1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [BLOCK_W-1:0] state,
    output logic               r1,
    output logic               r2,
    output logic [2:0]         seq_state
);

    logic       match0, match1, match2, match3;
    logic [2:0] next_state;
    logic [7:0] occ_cnt, occ_cnt_next;
    logic       byte_hit;

    tsc_pattern_cmp #(.PATTERN(P0), .MASK(PMASK)) u_cmp0 (.state(state), .match(match0));
    tsc_pattern_cmp #(.PATTERN(P1), .MASK(PMASK)) u_cmp1 (.state(state), .match(match1));
    tsc_pattern_cmp #(.PATTERN(P2), .MASK(PMASK)) u_cmp2 (.state(state), .match(match2));
    tsc_pattern_cmp #(.PATTERN(P3), .MASK(PMASK)) u_cmp3 (.state(state), .match(match3));

`ifdef TSC_ARM_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (seq_state == ARMED) && !in_valid && (tmo_cnt == TIMEOUT - 16'd1);

    // Counts consecutive idle cycles spent in ARMED.
    always_ff @(posedge clk) begin
        if (rst || in_valid || seq_state != ARMED) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    localparam logic [15:0] timeout_unused = TIMEOUT;
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    // Advance is checked before the P0 restart so it wins when patterns coincide.
    always_comb begin
        next_state = seq_state;
        if (in_valid) begin
            case (seq_state)
                S0:      next_state = match0 ? S1 : S0;
                S1:      next_state = match1 ? S2 : (match0 ? S1 : S0);
                S2:      next_state = match2 ? S3 : (match0 ? S1 : S0);
                S3:      next_state = match3 ? ARMED : (match0 ? S1 : S0);
                ARMED:   next_state = ARMED;
                default: next_state = S0;
            endcase
        end else if (tmo_hit) begin
            next_state = S0;
        end
    end

    assign byte_hit     = in_valid && (state[7:0] == R2_BYTE);
    assign occ_cnt_next = (byte_hit && occ_cnt != 8'hFF) ? occ_cnt + 8'd1 : occ_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state <= S0;
            occ_cnt   <= 8'd0;
            r1        <= 1'b0;
            r2        <= 1'b0;
        end else begin
            seq_state <= next_state;
            occ_cnt   <= occ_cnt_next;
            r1        <= (next_state == ARMED);
            r2        <= (occ_cnt_next >= R2_THRESH);
        end
    end

endmodule

// File: tb/tb_tsc_rare_event_gen.sv
// Randomized self-checking bench for tsc_rare_event_gen against a sequence /
// occurrence-count model; honours TSC_ARM_TIMEOUT_EN when defined.
module tb_tsc_rare_event_gen;

    localparam logic [15:0] TB_TIMEOUT = 16'd10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] state;
    logic         r1, r2;
    logic [2:0]   seq_state;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: progress through the pattern list, byte occurrences.
    logic [127:0] pat [4];
    int           progress;
    int           occurrences;
    int           idle;

    tsc_rare_event_gen #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .state     (state),
        .r1        (r1),
        .r2        (r2),
        .seq_state (seq_state)
    );

    always #5 clk = ~clk;

    task automatic modelStep(input logic r, input logic v, input logic [127:0] d);
        if (r) begin
            progress    = 0;
            occurrences = 0;
            idle        = 0;
        end else if (v) begin
            idle = 0;
            if (progress < 4) begin
                if (d == pat[progress])  progress = progress + 1;
                else if (d == pat[0])    progress = 1;
                else                     progress = 0;
            end
            if (d[7:0] == 8'hA5 && occurrences < 255) occurrences = occurrences + 1;
        end else if (progress == 4) begin
`ifdef TSC_ARM_TIMEOUT_EN
            idle = idle + 1;
            if (idle == int'(TB_TIMEOUT)) begin
                progress = 0;
                idle     = 0;
            end
`endif
        end
    endtask

    task automatic checkOutput();
        logic [2:0] expState;
        logic       expR1, expR2;
        expState = 3'(progress);
        expR1    = (progress == 4);
        expR2    = (occurrences >= 3);
        vectors  = vectors + 1;
        if (seq_state !== expState || r1 !== expR1 || r2 !== expR2) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL cycle-compare t=%0t: got seq_state=%0d r1=%b r2=%b, expected seq_state=%0d r1=%b r2=%b",
                     $time, seq_state, r1, r2, expState, expR1, expR2);
        end
    endtask

    task automatic checkLiteral(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors = vectors + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [127:0] d);
        rst      = r;
        in_valid = v;
        state    = d;
        @(posedge clk);
        modelStep(r, v, d);
        #1;
        checkOutput();
    endtask

    task automatic block(input logic [127:0] d);
        applyStimulus(1'b0, 1'b1, d);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 128'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 128'h0);
    endtask

    initial begin
        logic [127:0] d;
        int           sel;

        pat[0] = 128'h1;
        pat[1] = 128'h2;
        pat[2] = 128'h3;
        pat[3] = 128'h4;
        progress = 0; occurrences = 0; idle = 0;
        rst = 1'b1; in_valid = 1'b0; state = 128'h0;

        // Reset state
        applyStimulus(1'b1, 1'b1, 128'h1);
        doReset();
        checkLiteral("reset_seq_state", {5'd0, seq_state}, 8'd0);
        checkLiteral("reset_r1", {7'd0, r1}, 8'd0);
        checkLiteral("reset_r2", {7'd0, r2}, 8'd0);

        // Straight sequence 1,2,3,4
        for (int i = 1; i <= 4; i++) begin
            block(128'(i));
            checkLiteral("seq_walk", {5'd0, seq_state}, 8'(i));
        end
        checkLiteral("seq_r1_armed", {7'd0, r1}, 8'd1);
        checkLiteral("seq_r2_quiet", {7'd0, r2}, 8'd0);
        block(128'h9);
        checkLiteral("armed_absorbing", {5'd0, seq_state}, 8'd4);

        // Broken sequence, then restart on repeated P0
        doReset();
        block(128'h1); block(128'h2); block(128'h9);
        checkLiteral("break_to_s0", {5'd0, seq_state}, 8'd0);
        block(128'h1); block(128'h1);
        checkLiteral("restart_keeps_s1", {5'd0, seq_state}, 8'd1);
        block(128'h2); block(128'h3); block(128'h4);
        checkLiteral("restart_armed_r1", {7'd0, r1}, 8'd1);

        // Occurrence threshold with gaps
        doReset();
        block(128'hA5); idleCycle(); block(128'h77A5); idleCycle();
        block(128'h5A); idleCycle();
        checkLiteral("r2_after_two", {7'd0, r2}, 8'd0);
        block({$urandom, $urandom, $urandom, 24'h0, 8'hA5});
        checkLiteral("r2_after_three", {7'd0, r2}, 8'd1);

        // Saturation
        for (int i = 0; i < 300; i++) block(128'hA5);
        checkLiteral("r2_saturated", {7'd0, r2}, 8'd1);

        // Reset in S2 and in ARMED
        doReset();
        block(128'h1); block(128'h2);
        checkLiteral("in_s2", {5'd0, seq_state}, 8'd2);
        doReset();
        checkLiteral("rst_from_s2", {5'd0, seq_state}, 8'd0);
        block(128'h2);
        checkLiteral("no_advance_after_rst", {5'd0, seq_state}, 8'd0);
        block(128'h1); block(128'h2); block(128'h3); block(128'h4);
        block(128'hA5); block(128'hA5); block(128'hA5);
        doReset();
        checkLiteral("rst_from_armed_r1", {7'd0, r1}, 8'd0);
        checkLiteral("rst_from_armed_r2", {7'd0, r2}, 8'd0);

        // X on state while idle
        block(128'h1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, {128{1'bx}});
        block(128'h2);
        checkLiteral("x_idle_no_effect", {5'd0, seq_state}, 8'd2);

`ifdef TSC_ARM_TIMEOUT_EN
        doReset();
        block(128'h1); block(128'h2); block(128'h3); block(128'h4);
        for (int i = 0; i < 9; i++) idleCycle();
        block(128'h9);
        for (int i = 0; i < 9; i++) idleCycle();
        checkLiteral("timeout_restart_r1", {7'd0, r1}, 8'd1);
        idleCycle();
        checkLiteral("timeout_to_s0", {5'd0, seq_state}, 8'd0);
        checkLiteral("timeout_r1_drop", {7'd0, r1}, 8'd0);
`endif

        // Randomized traffic
        doReset();
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: d = pat[sel];
                4, 5:       d = pat[0];
                6:          d = {$urandom, $urandom, $urandom, 24'h0, 8'hA5};
                7:          d = 128'h9;
                default:    d = {$urandom, $urandom, $urandom, $urandom};
            endcase
            if ($urandom_range(0, 199) == 0)      applyStimulus(1'b1, 1'b0, d);
            else if ($urandom_range(0, 3) == 0)   applyStimulus(1'b0, 1'b0, d);
            else                                  applyStimulus(1'b0, 1'b1, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
